instr_encoder_loader: RTL and testbench
=======================================

INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the word-address width of the instruction memory write port.
REQ-002 Parameter BASE_ADDR, default 0, SHALL set the first word address written after start.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse that begins a load session.
REQ-006 finish  in  1  one-cycle pulse that ends a load session.
REQ-007 in_valid  in  1  producer holds an instruction request.
REQ-008 in_ready  out  1  encoder accepts a request this cycle.
REQ-009 op_sel  in  4  0=RTYPE 1=BEQ 2=BNE 3=LW 4=SW 5=ADDI 6=ANDI 7=ORI 8=SLTI 9=LUI 10=J 11=JR; 12-15 illegal.
REQ-010 rs, rt, rd, shamt  in  5 each  register and shift fields.
REQ-011 funct  in  6; imm  in  16; target  in  26  instruction fields.
REQ-012 imem_we  out  1  write strobe to instruction memory.
REQ-013 imem_addr  out  ADDR_W  word address of the write.
REQ-014 imem_wdata  out  32  encoded instruction word.
REQ-015 count  out  ADDR_W+1  words written this session.
REQ-016 done  out  1  one-cycle pulse when a session ends.
REQ-017 err  out  1  sticky illegal-op flag, cleared by start.

Function
REQ-018 FSM states SHALL be IDLE, RUN, FULL; start in IDLE -> RUN, and start in any other state SHALL be ignored.
REQ-019 On start: write pointer <= BASE_ADDR, count <= 0, err <= 0.
REQ-020 in_ready SHALL be 1 only in RUN; a transfer occurs when in_valid & in_ready.
REQ-021 A transfer in cycle N SHALL produce imem_we=1 in cycle N+1, with registered imem_addr=pointer and imem_wdata=encoding; throughput SHALL be one word per cycle.
REQ-022 Encodings are {opcode[31:26], rs, rt, rd/imm...}: RTYPE 000000 {rs,rt,rd,shamt,funct}; BEQ 000100, BNE 000101, LW 100011, SW 101011, ADDI 001000, ANDI 001100, ORI 001101, SLTI 001010 all {rs,rt,imm}; LUI 001111 {5'b0,rt,imm}; J 000010 {target}; JR 010000 {rs,21'b0}.
REQ-023 Each write SHALL advance the pointer by 1 and increment count.
REQ-024 If the write lands at address 2^ADDR_W-1, the FSM SHALL go RUN -> FULL, drop in_ready in the following cycle, and pulse done; the pointer SHALL NOT wrap.
REQ-025 finish in RUN SHALL go -> IDLE and pulse done one cycle later; a transfer in the same cycle as finish SHALL still be written.
REQ-026 FULL SHALL remain until finish (-> IDLE, no second done pulse) or reset.
REQ-027 imem_we SHALL be 0 in every cycle without a preceding transfer.

Reset
REQ-028 reset SHALL force IDLE, in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, done=0, err=0.
REQ-029 reset mid-session SHALL abort it: a pending write SHALL be dropped and done SHALL NOT pulse.

Configuration
REQ-030 With ENC_ILLEGAL_TRAP_EN defined, an illegal op_sel transfer SHALL set err, write nothing, and leave pointer/count unchanged.
REQ-031 Without ENC_ILLEGAL_TRAP_EN, an illegal op_sel SHALL be written as 32'h0000_0000 (NOP), and err SHALL be tied to 0.

Verification
REQ-032 start; ADDI rs=1 rt=2 imm=16'h0005 -> next cycle imem_we=1, addr=0x00, wdata=0x2022_0005.
REQ-033 RTYPE rs=1 rt=2 rd=3 shamt=0 funct=0x20, then J target=0x10, back-to-back -> wdata 0x0022_1820 @0x00 and 0x0800_0010 @0x01.
REQ-034 JR rs=31 -> wdata 0x43E0_0000; LUI rt=4 imm=0x1234 -> wdata 0x3C04_1234.
REQ-035 BASE_ADDR=0xFE; stream 3 valid words -> writes @0xFE and 0xFF, done pulse, in_ready=0, third word not taken, count=2.
REQ-036 op_sel=13 -> trap build: err=1, no write; non-trap build: wdata=0 written. reset during RUN with transfer pending -> no write, no done.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
// Encodes instruction requests into 32-bit MIPS-style words and writes them
// sequentially into instruction memory during a start/finish load session.
// Optional feature macro: ENC_ILLEGAL_TRAP_EN. When it is defined, an illegal
// op_sel sets the sticky err flag and nothing is written. When it is not
// defined, an illegal op_sel is written as a NOP and err reads 0.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | no session; waiting for start
// ST_RUN  | accepting requests, one word written per accepted request
// ST_FULL | last address written; holding until finish or reset
module instr_encoder_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              finish_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        op_sel_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        shamt_i,
  input  logic [5:0]        funct_i,
  input  logic [15:0]       imm_i,
  input  logic [25:0]       target_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic [ADDR_W:0]   count_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic [31:0]       enc_word;
  logic              xfer;
  logic              wr_en;

  assign xfer = in_valid_i & (state_q == ST_RUN);

`ifdef ENC_ILLEGAL_TRAP_EN
  logic err_q, err_d;
  logic illegal_op;

  assign illegal_op = (op_sel_i > 4'd11);
  assign wr_en      = xfer & ~illegal_op;
  assign err_o      = err_q;
`else
  assign wr_en      = xfer;
  assign err_o      = 1'b0;
`endif

  // Instruction encoding; illegal selectors fall through to an all-zero NOP.
  always_comb begin
    enc_word = 32'h0000_0000;
    case (op_sel_i)
      4'd0:    enc_word = {6'b000000, rs_i, rt_i, rd_i, shamt_i, funct_i};
      4'd1:    enc_word = {6'b000100, rs_i, rt_i, imm_i};
      4'd2:    enc_word = {6'b000101, rs_i, rt_i, imm_i};
      4'd3:    enc_word = {6'b100011, rs_i, rt_i, imm_i};
      4'd4:    enc_word = {6'b101011, rs_i, rt_i, imm_i};
      4'd5:    enc_word = {6'b001000, rs_i, rt_i, imm_i};
      4'd6:    enc_word = {6'b001100, rs_i, rt_i, imm_i};
      4'd7:    enc_word = {6'b001101, rs_i, rt_i, imm_i};
      4'd8:    enc_word = {6'b001010, rs_i, rt_i, imm_i};
      4'd9:    enc_word = {6'b001111, 5'b00000, rt_i, imm_i};
      4'd10:   enc_word = {6'b000010, target_i};
      4'd11:   enc_word = {6'b010000, rs_i, 21'b0};
      default: enc_word = 32'h0000_0000;
    endcase
  end

  // Next-state and registered-output logic for the load session.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
`ifdef ENC_ILLEGAL_TRAP_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          ptr_d   = PTR_BASE;
          count_d = '0;
`ifdef ENC_ILLEGAL_TRAP_EN
          err_d   = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        if (wr_en) begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = enc_word;
          count_d = count_q + CNT_ONE;
          // The top address is written once and the pointer parks there.
          if (ptr_q == PTR_LAST) begin
            state_d = ST_FULL;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + PTR_ONE;
          end
        end
`ifdef ENC_ILLEGAL_TRAP_EN
        if (xfer && illegal_op) begin
          err_d = 1'b1;
        end
`endif
        // A same-cycle transfer is still written; only one done pulse results.
        if (finish_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_FULL: begin
        if (finish_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= PTR_BASE;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= PTR_BASE;
      wdata_q <= 32'h0000_0000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

`ifdef ENC_ILLEGAL_TRAP_EN
  // Sticky illegal-op flag, cleared by reset or a new session.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

  assign in_ready_o   = (state_q == ST_RUN);
  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign count_o      = count_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: two instances (base 0x00 and base 0xFE)
// share one stimulus stream; a behavioural model predicts both every cycle,
// and directed steps pin hand-computed encodings and boundary behaviour.
`timescale 1ns/1ps
module tb_instr_encoder_loader;

  localparam int AW = 8;
`ifdef ENC_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, finish, in_valid;
  logic [3:0]  op_sel;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;

  logic        d_ready [2];
  logic        d_we    [2];
  logic [AW-1:0] d_addr [2];
  logic [31:0] d_wdata [2];
  logic [AW:0] d_count [2];
  logic        d_done  [2];
  logic        d_err   [2];

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut0 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .finish_i(finish),
    .in_valid_i(in_valid), .in_ready_o(d_ready[0]), .op_sel_i(op_sel),
    .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt), .funct_i(funct),
    .imm_i(imm), .target_i(target), .imem_we_o(d_we[0]), .imem_addr_o(d_addr[0]),
    .imem_wdata_o(d_wdata[0]), .count_o(d_count[0]), .done_o(d_done[0]), .err_o(d_err[0])
  );

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(254)) dut1 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .finish_i(finish),
    .in_valid_i(in_valid), .in_ready_o(d_ready[1]), .op_sel_i(op_sel),
    .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt), .funct_i(funct),
    .imm_i(imm), .target_i(target), .imem_we_o(d_we[1]), .imem_addr_o(d_addr[1]),
    .imem_wdata_o(d_wdata[1]), .count_o(d_count[1]), .done_o(d_done[1]), .err_o(d_err[1])
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          base_of [2] = '{0, 254};
  int          m_mode  [2];   // 0 no session, 1 loading, 2 memory full
  int          m_ptr   [2];
  int          m_cnt   [2];
  bit          m_err   [2];
  bit          e_we    [2];
  bit          e_done  [2];
  bit          e_ready [2];
  int          e_addr  [2];
  logic [31:0] e_wdata [2];
  bit          model_live = 1'b0;

  function automatic logic [31:0] model_encode(input int op, input int f_rs, input int f_rt,
                                               input int f_rd, input int f_sh, input int f_fn,
                                               input int f_imm, input int f_tgt);
    int     opcode_tab [12] = '{0, 4, 5, 35, 43, 8, 12, 13, 10, 15, 2, 16};
    longint w;
    logic [63:0] wv;
    if (op > 11) return 32'h0;
    w = longint'(opcode_tab[op]) * 64'd67108864;
    if (op == 0)
      w = w + f_rs * 64'd2097152 + f_rt * 64'd65536 + f_rd * 64'd2048 + f_sh * 64'd64 + f_fn;
    else if (op <= 8)
      w = w + f_rs * 64'd2097152 + f_rt * 64'd65536 + f_imm;
    else if (op == 9)
      w = w + f_rt * 64'd65536 + f_imm;
    else if (op == 10)
      w = w + f_tgt;
    else
      w = w + f_rs * 64'd2097152;
    wv = 64'(w);
    return wv[31:0];
  endfunction

  always @(posedge clk) begin
    model_live = 1'b1;
    for (int k = 0; k < 2; k++) begin
      e_we[k]   = 1'b0;
      e_done[k] = 1'b0;
      if (reset) begin
        m_mode[k] = 0; m_ptr[k] = base_of[k]; m_cnt[k] = 0; m_err[k] = 1'b0;
        e_addr[k] = base_of[k]; e_wdata[k] = 32'h0;
      end else if (m_mode[k] == 0) begin
        if (start) begin
          m_mode[k] = 1; m_ptr[k] = base_of[k]; m_cnt[k] = 0; m_err[k] = 1'b0;
        end
      end else if (m_mode[k] == 1) begin
        if (in_valid) begin
          if (TRAP && op_sel > 4'd11) begin
            m_err[k] = 1'b1;
          end else begin
            e_we[k]    = 1'b1;
            e_addr[k]  = m_ptr[k];
            e_wdata[k] = model_encode(int'(op_sel), int'(rs), int'(rt), int'(rd),
                                      int'(shamt), int'(funct), int'(imm), int'(target));
            m_cnt[k]++;
            if (m_ptr[k] == (1 << AW) - 1) begin
              m_mode[k] = 2;
              e_done[k] = 1'b1;
            end else begin
              m_ptr[k]++;
            end
          end
        end
        if (finish) begin
          m_mode[k] = 0;
          e_done[k] = 1'b1;
        end
      end else if (finish) begin
        m_mode[k] = 0;
      end
      e_ready[k] = (m_mode[k] == 1);
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (model_live) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("inst%0d in_ready", k), 64'(d_ready[k]), 64'(e_ready[k]));
        chk($sformatf("inst%0d imem_we", k),  64'(d_we[k]),    64'(e_we[k]));
        chk($sformatf("inst%0d count", k),    64'(d_count[k]), 64'(m_cnt[k]));
        chk($sformatf("inst%0d done", k),     64'(d_done[k]),  64'(e_done[k]));
        chk($sformatf("inst%0d err", k),      64'(d_err[k]),   64'(m_err[k]));
        if (e_we[k]) begin
          chk($sformatf("inst%0d imem_addr", k),  64'(d_addr[k]),  64'(e_addr[k]));
          chk($sformatf("inst%0d imem_wdata", k), 64'(d_wdata[k]), 64'(e_wdata[k]));
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic put(input int op, input int a_rs, input int a_rt, input int a_rd,
                     input int a_sh, input int a_fn, input int a_imm, input int a_tgt);
    in_valid = 1'b1;
    op_sel = 4'(op); rs = 5'(a_rs); rt = 5'(a_rt); rd = 5'(a_rd);
    shamt = 5'(a_sh); funct = 6'(a_fn); imm = 16'(a_imm); target = 26'(a_tgt);
  endtask

  task automatic lit(input int k, input int addr, input logic [31:0] data);
    chk($sformatf("lit inst%0d we", k),    64'(d_we[k]),    64'd1);
    chk($sformatf("lit inst%0d addr", k),  64'(d_addr[k]),  64'(addr));
    chk($sformatf("lit inst%0d wdata", k), 64'(d_wdata[k]), 64'(data));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    put(0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst inst%0d ready", k), 64'(d_ready[k]), 64'd0);
      chk($sformatf("rst inst%0d we", k),    64'(d_we[k]),    64'd0);
      chk($sformatf("rst inst%0d addr", k),  64'(d_addr[k]),  64'(base_of[k]));
      chk($sformatf("rst inst%0d wdata", k), 64'(d_wdata[k]), 64'd0);
      chk($sformatf("rst inst%0d count", k), 64'(d_count[k]), 64'd0);
      chk($sformatf("rst inst%0d done", k),  64'(d_done[k]),  64'd0);
      chk($sformatf("rst inst%0d err", k),   64'(d_err[k]),   64'd0);
    end
    reset = 1'b0;
    tick();

    // ADDI rs=1 rt=2 imm=5
    start = 1'b1; tick(); start = 1'b0;
    chk("ready after start", 64'(d_ready[0]), 64'd1);
    put(5, 1, 2, 0, 0, 0, 16'h0005, 0); tick(); in_valid = 1'b0;
    lit(0, 8'h00, 32'h2022_0005);
    lit(1, 8'hFE, 32'h2022_0005);
    chk("model pin addi", 64'(e_wdata[0]), 64'h2022_0005);
    finish = 1'b1; tick(); finish = 1'b0;
    chk("finish done inst0", 64'(d_done[0]), 64'd1);
    tick();
    chk("done one cycle", 64'(d_done[0]), 64'd0);

    // back-to-back RTYPE, J, JR, LUI; instance 1 fills at 0xFF after two words
    start = 1'b1; tick(); start = 1'b0;
    put(0, 1, 2, 3, 0, 6'h20, 0, 0); tick();
    lit(0, 8'h00, 32'h0022_1820);
    lit(1, 8'hFE, 32'h0022_1820);
    put(10, 0, 0, 0, 0, 0, 0, 26'h10); tick();
    lit(0, 8'h01, 32'h0800_0010);
    lit(1, 8'hFF, 32'h0800_0010);
    chk("model pin j", 64'(e_wdata[0]), 64'h0800_0010);
    chk("full done inst1", 64'(d_done[1]), 64'd1);
    chk("full ready inst1", 64'(d_ready[1]), 64'd0);
    put(11, 31, 0, 0, 0, 0, 0, 0); tick();
    lit(0, 8'h02, 32'h43E0_0000);
    chk("third word not taken", 64'(d_we[1]), 64'd0);
    put(9, 0, 4, 0, 0, 0, 16'h1234, 0); tick();
    lit(0, 8'h03, 32'h3C04_1234);
    chk("model pin lui", 64'(e_wdata[0]), 64'h3C04_1234);
    chk("full count inst1", 64'(d_count[1]), 64'd2);
    chk("full done once inst1", 64'(d_done[1]), 64'd0);

    // illegal op_sel 13
    put(13, 1, 1, 1, 1, 1, 1, 1); tick(); in_valid = 1'b0;
    if (TRAP) begin
      chk("illegal no write", 64'(d_we[0]), 64'd0);
      chk("illegal err", 64'(d_err[0]), 64'd1);
      chk("illegal count", 64'(d_count[0]), 64'd4);
    end else begin
      lit(0, 8'h04, 32'h0000_0000);
      chk("illegal err tied", 64'(d_err[0]), 64'd0);
      chk("illegal count", 64'(d_count[0]), 64'd5);
    end
    finish = 1'b1; tick(); finish = 1'b0;
    chk("finish done inst0 b", 64'(d_done[0]), 64'd1);
    chk("finish in full no done", 64'(d_done[1]), 64'd0);
    tick();

    // reset with a transfer pending
    start = 1'b1; tick(); start = 1'b0;
    put(5, 1, 2, 0, 0, 0, 16'h0005, 0); reset = 1'b1; tick(); in_valid = 1'b0;
    chk("abort no write", 64'(d_we[0]), 64'd0);
    chk("abort no done", 64'(d_done[0]), 64'd0);
    chk("abort count", 64'(d_count[0]), 64'd0);
    reset = 1'b0; tick();
    chk("abort later no done", 64'(d_done[0]), 64'd0);

    // start ignored while running; transfer on the finish cycle still written
    start = 1'b1; tick(); start = 1'b0;
    put(5, 3, 4, 0, 0, 0, 16'hFFFF, 0); tick();
    lit(0, 8'h00, 32'h2064_FFFF);
    start = 1'b1; put(7, 0, 7, 0, 0, 0, 16'h00F0, 0); tick(); start = 1'b0;
    lit(0, 8'h01, 32'h3407_00F0);
    put(4, 29, 8, 0, 0, 0, 16'h0010, 0); finish = 1'b1; tick();
    finish = 1'b0; in_valid = 1'b0;
    lit(0, 8'h02, 32'hAFA8_0010);
    chk("finish with xfer done", 64'(d_done[0]), 64'd1);
    tick();
    chk("idle ready", 64'(d_ready[0]), 64'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
